pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 PCSrc  input  2  next-PC select from branch logic: 00 = PC+4, 01 = PC+immExt, 10 = aluResult (jalr), 11 = PC+4.
REQ-005 immExt  input  32  sign-extended branch/jal offset.
REQ-006 aluResult  input  32  jalr target address.
REQ-007 advance  input  1  core retires the held instruction this cycle.
REQ-008 imem_ready  input  1  instruction memory returns imem_rdata this cycle.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 imem_req  output  1  fetch request to instruction memory.
REQ-011 imem_addr  output  32  fetch address; always equal to PC.
REQ-012 instr  output  32  held instruction word.
REQ-013 instr_valid  output  1  instr is valid for the core.
REQ-014 PC  output  32  current program counter.
REQ-015 PCPlus4  output  32  PC+4, combinational, modulo 2^32.
REQ-016 misaligned  output  1  sticky flag: a misaligned target was selected.

Function
REQ-017 The block SHALL implement an FSM with states FETCH, HOLD and TRAP.
REQ-018 FETCH: imem_req=1, instr_valid=0; on imem_ready=1 it SHALL register imem_rdata into instr and move to HOLD next cycle.
REQ-019 HOLD: imem_req=0, instr_valid=1, instr stable; without advance it SHALL stay in HOLD indefinitely.
REQ-020 HOLD with advance=1: next target = PC+4 (00/11), PC+immExt (01), {aluResult[31:1],1'b0} (10).
REQ-021 If target[1]=0, PC SHALL load target and the FSM SHALL return to FETCH next cycle.
REQ-022 If target[1]=1, PC SHALL keep its value, misaligned SHALL set to 1 and the FSM SHALL enter TRAP.
REQ-023 TRAP: imem_req=0, instr_valid=0, misaligned=1; TRAP SHALL exit only via reset.
REQ-024 All adds SHALL be 32-bit modulo 2^32 (PC 32'hFFFF_FFFC + 4 = 32'h0000_0000), with no overflow flag.
REQ-025 imem_ready and imem_rdata SHALL be ignored outside FETCH; advance SHALL be ignored outside HOLD.
REQ-026 Minimum throughput: one instruction per 2 cycles (FETCH with imem_ready=1, then HOLD with advance=1).
REQ-027 instr_valid SHALL rise in the cycle after the FETCH cycle in which imem_ready=1.

Reset
REQ-028 On reset, asserted at any time including mid-fetch or in TRAP: state=FETCH, PC=RESET_VECTOR, instr=32'h0000_0013 (nop), misaligned=0.
REQ-029 Outputs during reset SHALL be imem_req=1, instr_valid=0, imem_addr=RESET_VECTOR.
REQ-030 The first fetch SHALL be issued in the first cycle after reset deasserts.

Structure
REQ-031 Package pc_fetch_pkg SHALL hold the FSM state enum and the PCSrc encoding constants (PC_PLUS4, PC_BRANCH, PC_JALR); the branch logic block SHALL share these constants.
REQ-032 The next-PC mux and adders SHALL live in one combinational sub-module, pc_next; the FSM and registers SHALL live in pc_fetch_unit.

Verification
REQ-033 Scenario: reset, imem_ready=1, rdata=32'h0050_0093, advance=1 with PCSrc=00 -> instr_valid after 1 cycle, then PC=4, imem_addr=4.
REQ-034 Scenario: PC=32'h100, PCSrc=01, immExt=32'hFFFF_FFF0, advance=1 -> PC=32'h0F0, state FETCH.
REQ-035 Scenario: PCSrc=10, aluResult=32'h0000_0207 -> target 32'h206, misaligned=1, PC unchanged, imem_req=0 held for 10+ cycles.
REQ-036 Scenario: imem_ready low for 5 cycles in FETCH -> imem_req stays 1, imem_addr stable, instr_valid=0; HOLD with advance low for 5 cycles -> instr unchanged.
REQ-037 Scenario: PC=32'hFFFF_FFFC, PCSrc=00, advance=1 -> PC=32'h0000_0000, misaligned=0.
REQ-038 Scenario: reset asserted in TRAP and mid-FETCH -> immediately PC=RESET_VECTOR, misaligned=0, instr=32'h0000_0013.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC fetch path: FSM state encoding and
// the PCSrc select values that the branch logic drives.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_TRAP  = 2'd2
  } fetch_state_t;

  // PCSrc encoding; 2'b11 is treated the same as PC_PLUS4.
  localparam logic [1:0] PC_PLUS4     = 2'b00;
  localparam logic [1:0] PC_BRANCH    = 2'b01;
  localparam logic [1:0] PC_JALR      = 2'b10;
  localparam logic [1:0] PC_PLUS4_ALT = 2'b11;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Only bit 1 is checked: targets are word-aligned unless bit 1 is set.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1];
  endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC datapath: PC+4 and PC+immExt adders plus the PCSrc target mux.
// Purely combinational; all adds wrap modulo 2^32.
module pc_next
  import pc_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_src,
  input  logic [31:0] imm_ext,
  input  logic [31:0] alu_result,
  output logic [31:0] pc_plus4,
  output logic [31:0] target,
  output logic        target_misaligned
);

  logic [31:0] pc_branch;
  logic [31:0] jalr_target;

  always_comb begin
    pc_plus4    = pc + 32'd4;
    pc_branch   = pc + imm_ext;
    // jalr drops bit 0 of the computed address
    jalr_target = alu_result & 32'hFFFF_FFFE;
  end

  always_comb begin
    target = pc_plus4;
    case (pc_src)
      PC_PLUS4:     target = pc_plus4;
      PC_BRANCH:    target = pc_branch;
      PC_JALR:      target = jalr_target;
      PC_PLUS4_ALT: target = pc_plus4;
      default:      target = pc_plus4;
    endcase
    target_misaligned = is_misaligned(target);
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and single-entry instruction fetch buffer. Issues a fetch,
// holds the returned word until the core advances, then redirects the PC.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] immExt,
  input  logic [31:0] aluResult,
  input  logic        advance,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        misaligned,
  output logic [1:0]  dbg_state
);

  // Handshakes: a fetch completes on a cycle with imem_req && imem_ready
  // (imem_rdata captured then); an instruction retires on a cycle with
  // instr_valid && advance. Neither side may retract its signal early, and
  // imem_ready / advance are ignored whenever the matching request is low.

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic         misaligned_q;

  logic [31:0]  pc_plus4;
  logic [31:0]  target;
  logic         target_misaligned;

  logic         fetch_done;
  logic         retire;

  pc_next u_pc_next (
    .pc                (pc_q),
    .pc_src            (PCSrc),
    .imm_ext           (immExt),
    .alu_result        (aluResult),
    .pc_plus4          (pc_plus4),
    .target            (target),
    .target_misaligned (target_misaligned)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fetch_done  = 1'b0;
    retire      = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req   = 1'b1;
        fetch_done = imem_ready;
        if (imem_ready) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        instr_valid = 1'b1;
        retire      = advance;
        if (advance) begin
          state_d = target_misaligned ? ST_TRAP : ST_FETCH;
        end
      end
      ST_TRAP: begin
        // Sticky until reset.
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_VECTOR;
      instr_q      <= NOP_INSTR;
      misaligned_q <= 1'b0;
    end else begin
      if (fetch_done) begin
        instr_q <= imem_rdata;
      end
      if (retire && !target_misaligned) begin
        pc_q <= target;
      end
      if (retire && target_misaligned) begin
        misaligned_q <= 1'b1;
      end
    end
  end

  always_comb begin
    PC         = pc_q;
    imem_addr  = pc_q;
    PCPlus4    = pc_plus4;
    instr      = instr_q;
    misaligned = misaligned_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: fetched words go through an expected
// queue and are compared when the held instruction becomes valid.
module tb_pc_fetch_unit;
  import pc_fetch_pkg::*;

  logic        clk;
  logic        reset;
  logic [1:0]  PCSrc;
  logic [31:0] immExt;
  logic [31:0] aluResult;
  logic        advance;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        misaligned;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_pc;
  logic [31:0] held_instr;

  localparam logic [31:0] S_FETCH = 32'd0;
  localparam logic [31:0] S_HOLD  = 32'd1;
  localparam logic [31:0] S_TRAP  = 32'd2;

  pc_fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .PCSrc       (PCSrc),
    .immExt      (immExt),
    .aluResult   (aluResult),
    .advance     (advance),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .instr       (instr),
    .instr_valid (instr_valid),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .misaligned  (misaligned),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver / checker tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"}, PC, 32'h0);
    check({tag, "_addr"}, imem_addr, 32'h0);
    check({tag, "_instr"}, instr, 32'h0000_0013);
    check({tag, "_mis"}, {31'd0, misaligned}, 32'd0);
    check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_state"}, {30'd0, dbg_state}, S_FETCH);
  endtask

  // Complete one fetch from FETCH; the word must be valid one cycle later.
  task automatic fetch_one(input logic [31:0] data);
    logic [31:0] exp;
    imem_ready = 1'b1;
    imem_rdata = data;
    exp_q.push_back(data);
    step();
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    check("fetch_valid", {31'd0, instr_valid}, 32'd1);
    check("fetch_req_low", {31'd0, imem_req}, 32'd0);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check("fetch_instr", instr, exp);
      held_instr = exp;
    end
  endtask

  task automatic do_advance(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu);
    logic [31:0] tgt;
    case (src)
      2'b01:   tgt = model_pc + imm;
      2'b10:   tgt = {alu[31:1], 1'b0};
      default: tgt = model_pc + 32'd4;
    endcase
    PCSrc     = src;
    immExt    = imm;
    aluResult = alu;
    advance   = 1'b1;
    step();
    advance = 1'b0;
    if (tgt[1]) begin
      check("trap_pc", PC, model_pc);
      check("trap_mis", {31'd0, misaligned}, 32'd1);
      check("trap_state", {30'd0, dbg_state}, S_TRAP);
    end else begin
      model_pc = tgt;
      check("adv_pc", PC, model_pc);
      check("adv_addr", imem_addr, model_pc);
      check("adv_plus4", PCPlus4, model_pc + 32'd4);
      check("adv_state", {30'd0, dbg_state}, S_FETCH);
      check("adv_mis", {31'd0, misaligned}, 32'd0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset      = 1'b1;
    PCSrc      = 2'b00;
    immExt     = 32'h0;
    aluResult  = 32'h0;
    advance    = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    model_pc   = 32'h0;
    held_instr = 32'h0000_0013;

    step();
    step();
    check_reset_outputs("rst");
    // Inputs must not disturb state while reset is held.
    imem_ready = 1'b1;
    advance    = 1'b1;
    step();
    check_reset_outputs("rst_hold");
    imem_ready = 1'b0;
    advance    = 1'b0;
    reset      = 1'b0;

    // First fetch in the first cycle after reset; then sequential advance.
    check("first_req", {31'd0, imem_req}, 32'd1);
    fetch_one(32'h0050_0093);
    check("hold_state", {30'd0, dbg_state}, S_HOLD);
    do_advance(2'b00, 32'h0, 32'h0);
    check("seq_pc4", PC, 32'h4);

    // jalr clears bit 0: 0x101 -> 0x100.
    fetch_one(32'h0000_8067);
    do_advance(2'b10, 32'h0, 32'h0000_0101);
    check("jalr_pc", PC, 32'h100);

    // Memory stall: request and address held, nothing valid.
    for (int i = 0; i < 5; i++) begin
      imem_rdata = $urandom;
      step();
      check("stall_req", {31'd0, imem_req}, 32'd1);
      check("stall_addr", imem_addr, 32'h100);
      check("stall_valid", {31'd0, instr_valid}, 32'd0);
    end

    // Core stall: instr stable while memory inputs toggle.
    fetch_one(32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      imem_ready = 1'(i % 2);
      imem_rdata = $urandom;
      step();
      check("hold_instr", instr, held_instr);
      check("hold_valid", {31'd0, instr_valid}, 32'd1);
      check("hold_pc", PC, 32'h100);
    end
    imem_ready = 1'b0;

    // Backward branch 0x100 - 16 = 0xF0.
    do_advance(2'b01, 32'hFFFF_FFF0, 32'h0);
    check("branch_pc", PC, 32'h0F0);

    // PCSrc 11 behaves as PC+4.
    fetch_one(32'h0000_0013);
    do_advance(2'b11, 32'h0000_0400, 32'h0000_0800);
    check("src11_pc", PC, 32'h0F4);

    // Mixed random aligned redirects.
    for (int i = 0; i < 8; i++) begin
      logic [1:0]  src;
      logic [31:0] imm;
      logic [31:0] alu;
      src = 2'($urandom_range(0, 3));
      imm = $urandom & 32'hFFFF_FFFC;
      alu = $urandom & 32'hFFFF_FFFD;
      fetch_one($urandom);
      do_advance(src, imm, alu);
    end

    // Wrap at the top of the address space.
    fetch_one(32'h0000_0067);
    do_advance(2'b10, 32'h0, 32'hFFFF_FFFC);
    check("top_plus4", PCPlus4, 32'h0000_0000);
    fetch_one(32'h0000_0013);
    do_advance(2'b00, 32'h0, 32'h0);
    check("wrap_pc", PC, 32'h0000_0000);
    check("wrap_mis", {31'd0, misaligned}, 32'd0);

    // Misaligned jalr 0x207 -> 0x206 traps with PC unchanged.
    fetch_one(32'h0000_0067);
    do_advance(2'b10, 32'h0, 32'h0000_0200);
    fetch_one(32'h0000_0067);
    do_advance(2'b10, 32'h0, 32'h0000_0207);
    check("trap_pc_fixed", PC, 32'h200);
    for (int i = 0; i < 12; i++) begin
      imem_ready = 1'b1;
      advance    = 1'b1;
      imem_rdata = $urandom;
      step();
      check("trap_req", {31'd0, imem_req}, 32'd0);
      check("trap_valid", {31'd0, instr_valid}, 32'd0);
      check("trap_sticky", {31'd0, misaligned}, 32'd1);
      check("trap_pc_hold", PC, 32'h200);
    end
    imem_ready = 1'b0;
    advance    = 1'b0;

    // Reset mid-cycle while in TRAP takes effect immediately.
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_trap");
    step();
    reset    = 1'b0;
    model_pc = 32'h0;

    // Misaligned branch target (PC + 6) also traps.
    fetch_one(32'h0000_0063);
    do_advance(2'b01, 32'h0000_0006, 32'h0);
    check("br_trap_pc", PC, 32'h0);

    // Back to a clean FETCH, move PC, then reset mid-fetch.
    reset = 1'b1;
    step();
    reset = 1'b0;
    fetch_one(32'hABCD_0013);
    do_advance(2'b01, 32'h0000_0040, 32'h0);
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_fetch");
    step();
    check_reset_outputs("rst_fetch_held");
    imem_ready = 1'b0;
    reset      = 1'b0;
    model_pc   = 32'h0;
    exp_q.delete();

    fetch_one(32'h0050_0093);
    do_advance(2'b00, 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

endmodule
